// File: rtl/reset_sequencer.sv
// Releases the core reset domains in order (memories, pipeline, fetch) after
// the synchronised reset drops; soft-reset requests and clock-ready loss re-run it.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready_i,
  input  logic       soft_rst_req,
  output logic       mem_rst,
  output logic       pipe_rst,
  output logic       fetch_en,
  output logic       rst_done,
  output logic [7:0] soft_cnt
);

  typedef enum logic [2:0] {
    S_RESET, S_HOLD, S_REL_MEM, S_REL_PIPE, S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             soft_acc;
  logic             mem_rst_nxt, pipe_rst_nxt, fetch_en_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    soft_acc  = 1'b0;
    if (state != S_RESET && soft_rst_req) begin
      soft_acc  = 1'b1;
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_RESET: begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
        S_HOLD: begin
          if (!ready_i)               cnt_nxt = '0;
          else if (cnt == HOLD_LAST) begin
            state_nxt = S_REL_MEM;
            cnt_nxt   = '0;
          end else                    cnt_nxt = cnt + 1'b1;
        end
        S_REL_MEM, S_REL_PIPE: begin
          if (!ready_i) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
          end else if (cnt == GAP_LAST) begin
            state_nxt = (state == S_REL_MEM) ? S_REL_PIPE : S_RUN;
            cnt_nxt   = '0;
          end else    cnt_nxt = cnt + 1'b1;
        end
        S_RUN: begin
          cnt_nxt = '0;
          if (!ready_i) state_nxt = S_HOLD;
        end
        default: begin
          state_nxt = S_RESET;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    mem_rst_nxt  = 1'b1;
    pipe_rst_nxt = 1'b1;
    fetch_en_nxt = 1'b0;
    case (state_nxt)
      S_REL_MEM:  mem_rst_nxt = 1'b0;
      S_REL_PIPE: begin
        mem_rst_nxt  = 1'b0;
        pipe_rst_nxt = 1'b0;
      end
      S_RUN: begin
        mem_rst_nxt  = 1'b0;
        pipe_rst_nxt = 1'b0;
        fetch_en_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      cnt      <= '0;
      mem_rst  <= 1'b1;
      pipe_rst <= 1'b1;
      fetch_en <= 1'b0;
      rst_done <= 1'b0;
      soft_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mem_rst  <= mem_rst_nxt;
      pipe_rst <= pipe_rst_nxt;
      fetch_en <= fetch_en_nxt;
      rst_done <= fetch_en_nxt;
      if (soft_acc && soft_cnt != 8'hFF) soft_cnt <= soft_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters: release timing,
// ready loss, soft resets, saturation and mid-sequence reset, plus ordering checks.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, ready_i, soft_rst_req;
  logic       mem_rst, pipe_rst, fetch_en, rst_done;
  logic [7:0] soft_cnt;

  int tests = 0;
  int fails = 0;

  // {mem_rst, pipe_rst, fetch_en, rst_done}
  localparam logic [3:0] O_HOLD = 4'b1100;
  localparam logic [3:0] O_MEM  = 4'b0100;
  localparam logic [3:0] O_PIPE = 4'b0000;
  localparam logic [3:0] O_RUN  = 4'b0011;

  reset_sequencer #(.HOLD_CYCLES(16), .STAGE_GAP(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ready_i(ready_i), .soft_rst_req(soft_rst_req),
    .mem_rst(mem_rst), .pipe_rst(pipe_rst), .fetch_en(fetch_en),
    .rst_done(rst_done), .soft_cnt(soft_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] ctl, input logic [7:0] sc);
    logic [11:0] obs, exp;
    obs = {mem_rst, pipe_rst, fetch_en, rst_done, soft_cnt};
    exp = {ctl, sc};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called right after the edge that put the DUT in HOLD with cnt=0.
  task automatic seq_check(input string tag, input logic [7:0] sc);
    step(15); chk({tag, "_hold15"}, O_HOLD, sc);
    step(1);  chk({tag, "_mem16"},  O_MEM,  sc);
    step(3);  chk({tag, "_mem19"},  O_MEM,  sc);
    step(1);  chk({tag, "_pipe20"}, O_PIPE, sc);
    step(3);  chk({tag, "_pipe23"}, O_PIPE, sc);
    step(1);  chk({tag, "_run24"},  O_RUN,  sc);
  endtask

  // Domain ordering invariants, sampled every cycle.
  logic prev_mem = 1'b1, prev_pipe = 1'b1, prev_fetch = 1'b0;
  always @(negedge clk) begin
    tests++;
    assert ((!fetch_en || !pipe_rst) && (pipe_rst || !mem_rst) && (fetch_en == rst_done)
            && !(prev_pipe && !pipe_rst && prev_mem)
            && !(!prev_fetch && fetch_en && prev_pipe)) else begin
      fails++;
      $error("FAIL order: got m%b p%b f%b d%b (prev m%b p%b f%b) want ordered release",
             mem_rst, pipe_rst, fetch_en, rst_done, prev_mem, prev_pipe, prev_fetch);
    end
    prev_mem   = mem_rst;
    prev_pipe  = pipe_rst;
    prev_fetch = fetch_en;
  end

  initial begin
    rst = 1'b1; ready_i = 1'b1; soft_rst_req = 1'b0;
    step(5);
    chk("reset_vals", O_HOLD, 8'd0);

    // Nominal release; E0 is the first edge with rst=0.
    rst = 1'b0;
    step(1);
    chk("e0_hold", O_HOLD, 8'd0);
    seq_check("nominal", 8'd0);

    // Ready loss during HOLD restarts the hold count.
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    step(4);
    ready_i = 1'b0;
    step(10);
    chk("ready_lost_hold", O_HOLD, 8'd0);
    ready_i = 1'b1;
    seq_check("ready_back", 8'd0);

    // Single-cycle soft reset in RUN.
    soft_rst_req = 1'b1; step(1); soft_rst_req = 1'b0;
    chk("soft_run", O_HOLD, 8'd1);
    seq_check("soft1", 8'd1);

    // Ready loss in RUN: back to HOLD, count unchanged.
    ready_i = 1'b0; step(1); ready_i = 1'b1;
    chk("ready_lost_run", O_HOLD, 8'd1);
    seq_check("ready_run", 8'd1);

    // Soft reset plus ready loss on the same edge while in REL_PIPE.
    soft_rst_req = 1'b1; step(1); soft_rst_req = 1'b0;
    chk("soft2", O_HOLD, 8'd2);
    step(21);
    chk("in_rel_pipe", O_PIPE, 8'd2);
    soft_rst_req = 1'b1; ready_i = 1'b0; step(1);
    soft_rst_req = 1'b0; ready_i = 1'b1;
    chk("soft_noready_pipe", O_HOLD, 8'd3);
    seq_check("soft3", 8'd3);

    // rst beats a soft request and clears the count.
    soft_rst_req = 1'b1; rst = 1'b1; step(1);
    chk("soft_with_rst", O_HOLD, 8'd0);

    // Request in RESET is ignored; held request saturates the count.
    rst = 1'b0; step(1);
    chk("soft_in_reset", O_HOLD, 8'd0);
    step(1);   chk("sat_1",   O_HOLD, 8'd1);
    step(253); chk("sat_254", O_HOLD, 8'd254);
    step(1);   chk("sat_255", O_HOLD, 8'd255);
    step(45);  chk("sat_300", O_HOLD, 8'd255);
    soft_rst_req = 1'b0;
    seq_check("after_sat", 8'd255);

    // rst at E0+22 (REL_PIPE) aborts, then the full sequence reruns.
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    step(21);
    chk("pre_abort_pipe", O_PIPE, 8'd0);
    rst = 1'b1; step(1);
    chk("abort_rst", O_HOLD, 8'd0);
    rst = 1'b0; step(1);
    seq_check("rerun", 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
